// File: rtl/cook_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cook_pkg
// Purpose  : Shared state encoding, default timing constants and power helper
//            for the cook sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cook_pkg;

  localparam int MAX_SEC     = 3599;
  localparam int QUICK_SEC   = 30;
  localparam int BEEP_SEC    = 3;
  localparam int DUTY_WINDOW = 10;

  localparam int TIME_W = 12;
  localparam int PWR_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Out-of-range power settings (0 or above 10) run at full power.
  function automatic logic [PWR_W-1:0] eff_power(input logic [PWR_W-1:0] level);
    if (level == 4'd0 || level > 4'd10) return 4'd10;
    return level;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Purpose  : Falling-edge event detector for an active-low push button.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic fall
);

  logic r_prev;
  logic r_armed;

  // A button held low through reset must be released once before it can fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= btn_n;
      r_armed <= r_armed | btn_n;
    end
  end

  assign fall = r_armed & r_prev & ~btn_n;

endmodule
`default_nettype wire

// File: rtl/cook_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cook_sequencer
// Purpose  : Microwave cook controller: load/quick-start, countdown, duty-cycled
//            magnetron, pause on door/stop, end-of-cook beep.
// Revision : 1.0 - initial release
// ============================================================================
module cook_sequencer #(
  parameter int MAX_SEC     = cook_pkg::MAX_SEC,
  parameter int QUICK_SEC   = cook_pkg::QUICK_SEC,
  parameter int BEEP_SEC    = cook_pkg::BEEP_SEC,
  parameter int DUTY_WINDOW = cook_pkg::DUTY_WINDOW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  input  logic        sec_tick,
  input  logic        load_en,
  input  logic [11:0] time_set,
  input  logic [3:0]  power_level,
  output logic        mag_on,
  output logic        timer_done,
  output logic [11:0] remaining,
  output logic [2:0]  state,
  output logic        beep
);
  import cook_pkg::*;

  localparam int PHASE_W = $clog2(DUTY_WINDOW + 1);
  localparam int CNT_W   = $clog2(BEEP_SEC + 2);

  localparam logic [11:0]        C_MAX        = 12'(MAX_SEC);
  localparam logic [11:0]        C_QUICK      = 12'((QUICK_SEC > MAX_SEC) ? MAX_SEC : QUICK_SEC);
  localparam logic [PHASE_W-1:0] C_PHASE_LAST = PHASE_W'(DUTY_WINDOW - 1);
  localparam logic [CNT_W-1:0]   C_BEEP_LAST  = CNT_W'((BEEP_SEC > 0) ? BEEP_SEC - 1 : 0);

  logic w_start;
  logic w_stop;
  logic w_clear;

  state_t             r_state,     w_state_nxt;
  logic [11:0]        r_remaining, w_rem_nxt;
  logic [PHASE_W-1:0] r_phase,     w_phase_nxt;
  logic [CNT_W-1:0]   r_beep_cnt,  w_cnt_nxt;
  logic               r_mag_q,     w_mag_nxt;
  logic               r_timer_done, w_done_nxt;

  btn_edge u_start (.clk(clk), .rst(rst), .btn_n(startn), .fall(w_start));
  btn_edge u_stop  (.clk(clk), .rst(rst), .btn_n(stopn),  .fall(w_stop));
  btn_edge u_clear (.clk(clk), .rst(rst), .btn_n(clearn), .fall(w_clear));

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_beep_cnt;
    w_done_nxt  = 1'b0;

    if (w_clear) begin
      w_state_nxt = ST_IDLE;
      w_rem_nxt   = '0;
      w_phase_nxt = '0;
      w_cnt_nxt   = '0;
    end else if (w_stop && (r_state inside {ST_COOK, ST_READY, ST_PAUSE})) begin
      if (r_state == ST_COOK) begin
        w_state_nxt = ST_PAUSE;
      end else begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = '0;
      end
    end else if (!door_closed && r_state == ST_COOK) begin
      w_state_nxt = ST_PAUSE;
    end else if (w_start && door_closed && (r_state inside {ST_IDLE, ST_READY, ST_PAUSE})) begin
      w_state_nxt = ST_COOK;
      // Resuming from PAUSE keeps the duty phase where it stopped.
      if (r_state != ST_PAUSE) w_phase_nxt = '0;
      if (r_state == ST_IDLE)  w_rem_nxt   = C_QUICK;
    end else if (load_en && (r_state inside {ST_IDLE, ST_READY})) begin
      if (time_set == '0) begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = '0;
      end else begin
        w_state_nxt = ST_READY;
        w_rem_nxt   = (time_set > C_MAX) ? C_MAX : time_set;
      end
    end else if (sec_tick) begin
      case (r_state)
        ST_COOK: begin
          w_phase_nxt = (r_phase >= C_PHASE_LAST) ? '0 : r_phase + PHASE_W'(1);
          if (r_remaining <= 12'd1) begin
            w_rem_nxt   = '0;
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_rem_nxt = r_remaining - 12'd1;
          end
        end
        ST_DONE: begin
          if (r_beep_cnt >= C_BEEP_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_beep_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    w_mag_nxt = (w_state_nxt == ST_COOK) &&
                (int'(w_phase_nxt) < int'(eff_power(power_level)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_phase      <= '0;
      r_beep_cnt   <= '0;
      r_mag_q      <= 1'b0;
      r_timer_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_rem_nxt;
      r_phase      <= w_phase_nxt;
      r_beep_cnt   <= w_cnt_nxt;
      r_mag_q      <= w_mag_nxt;
      r_timer_done <= w_done_nxt;
    end
  end

  // Door interlock acts without waiting for a clock edge.
  assign mag_on     = r_mag_q & door_closed;
  assign timer_done = r_timer_done;
  assign remaining  = r_remaining;
  assign state      = r_state;
  assign beep       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cook_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cook_sequencer
// Purpose  : Directed vector table plus hand sequences for cook_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cook_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        startn, stopn, clearn, door_closed, sec_tick, load_en;
  logic [11:0] time_set;
  logic [3:0]  power_level;
  logic        mag_on, timer_done, beep;
  logic [11:0] remaining;
  logic [2:0]  state;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        startn, stopn, clearn, door, tick, load;
    logic [11:0] ts;
    logic [3:0]  pwr;
    int          e_state, e_rem, e_mag, e_done, e_beep;
  } vec_t;

  vec_t vecs[$];

  cook_sequencer dut (
    .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .sec_tick(sec_tick), .load_en(load_en),
    .time_set(time_set), .power_level(power_level), .mag_on(mag_on),
    .timer_done(timer_done), .remaining(remaining), .state(state), .beep(beep)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int s, input int p, input int c, input int d,
                              input int t, input int l, input int ts, input int pwr,
                              input int es, input int er, input int em,
                              input int ed, input int eb);
    vec_t v;
    v.startn = s[0]; v.stopn = p[0]; v.clearn = c[0]; v.door = d[0];
    v.tick = t[0]; v.load = l[0]; v.ts = 12'(ts); v.pwr = 4'(pwr);
    v.e_state = es; v.e_rem = er; v.e_mag = em; v.e_done = ed; v.e_beep = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input int st, input int rem,
                         input int mag, input int done, input int bp);
    chk({tag, ".state"},      int'(state),      st);
    chk({tag, ".remaining"},  int'(remaining),  rem);
    chk({tag, ".mag_on"},     int'(mag_on),     mag);
    chk({tag, ".timer_done"}, int'(timer_done), done);
    chk({tag, ".beep"},       int'(beep),       bp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    sec_tick = 1'b0;
    load_en  = 1'b0;
  endtask

  task automatic do_clear();
    clearn = 1'b0; cyc();
    clearn = 1'b1; cyc();
    chk("clear.state", int'(state), 0);
    chk("clear.remaining", int'(remaining), 0);
  endtask

  task automatic do_load(input int t);
    time_set = 12'(t); load_en = 1'b1; cyc();
  endtask

  task automatic press_start();
    startn = 1'b0; cyc();
    startn = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
    sec_tick = 1'b0; load_en = 1'b0; time_set = '0; power_level = 4'd10;
    #3;
    chk_out("reset", 0, 0, 0, 0, 0);
    #9 rst = 1'b0;

    // Full 5 s cook at power 10, then 3-tick beep back to IDLE.
    vecs.push_back(mk(1,1,1,1,0,0,0,10, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,1,0,1,5,10, 1,5,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,0,10, 2,5,1,0,0));
    for (int k = 4; k >= 1; k--) vecs.push_back(mk(1,1,1,1,1,0,0,10, 2,k,1,0,0));
    vecs.push_back(mk(1,1,1,1,1,0,0,10, 4,0,0,1,1));
    vecs.push_back(mk(1,1,1,1,0,0,0,10, 4,0,0,0,1));
    vecs.push_back(mk(1,1,1,1,1,0,0,10, 4,0,0,0,1));
    vecs.push_back(mk(1,1,1,1,1,0,0,10, 4,0,0,0,1));
    vecs.push_back(mk(1,1,1,1,1,0,0,10, 0,0,0,0,0));
    // Load boundaries, then power 3 duty cycle over 10 ticks.
    vecs.push_back(mk(1,1,1,1,0,1,7,3, 1,7,0,0,0));
    vecs.push_back(mk(1,1,1,1,0,1,0,3, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,1,0,1,20,3, 1,20,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,0,3, 2,20,1,0,0));
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(1,1,1,1,1,0,0,3, 2,20-k,((k%10)<3)?1:0,0,0));
    vecs.push_back(mk(1,1,1,1,0,1,5,3, 2,10,1,0,0));

    foreach (vecs[i]) begin
      startn = vecs[i].startn; stopn = vecs[i].stopn; clearn = vecs[i].clearn;
      door_closed = vecs[i].door; sec_tick = vecs[i].tick; load_en = vecs[i].load;
      time_set = vecs[i].ts; power_level = vecs[i].pwr;
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_rem,
              vecs[i].e_mag, vecs[i].e_done, vecs[i].e_beep);
    end
    sec_tick = 1'b0; load_en = 1'b0;
    do_clear();

    // Door opens mid-cook; phase must survive the pause.
    power_level = 4'd3;
    do_load(10);
    press_start();
    sec_tick = 1'b1; cyc();
    sec_tick = 1'b1; cyc();
    chk_out("door.pre", 2, 8, 1, 0, 0);
    door_closed = 1'b0; #1;
    chk("door.mag_comb", int'(mag_on), 0);
    chk("door.state_same", int'(state), 2);
    cyc();
    chk("door.pause", int'(state), 3);
    repeat (3) begin sec_tick = 1'b1; cyc(); end
    chk_out("door.ticks", 3, 8, 0, 0, 0);
    door_closed = 1'b1; cyc();
    press_start();
    chk_out("door.resume", 2, 8, 1, 0, 0);
    sec_tick = 1'b1; cyc();
    chk_out("door.phase3", 2, 7, 0, 0, 0);
    do_clear();

    // Quick start and load clamp.
    power_level = 4'd10;
    press_start();
    chk_out("quick", 2, 30, 1, 0, 0);
    do_clear();
    do_load(4000);
    chk_out("clamp", 1, 3599, 0, 0, 0);

    // Clear beats start in the same cycle; held start fires once.
    clearn = 1'b0; startn = 1'b0; cyc();
    chk_out("clr_vs_start", 0, 0, 0, 0, 0);
    clearn = 1'b1; startn = 1'b1; cyc();
    do_load(6);
    startn = 1'b0; cyc();
    chk("hold.first", int'(state), 2);
    stopn = 1'b0; cyc();
    stopn = 1'b1;
    chk("hold.stop", int'(state), 3);
    repeat (48) cyc();
    chk_out("hold.50", 3, 6, 0, 0, 0);
    startn = 1'b1; cyc();
    press_start();
    chk_out("hold.repress", 2, 6, 1, 0, 0);
    do_clear();

    // Async reset mid-cook, with start held low across it.
    do_load(15);
    press_start();
    repeat (3) begin sec_tick = 1'b1; cyc(); end
    chk_out("rst.pre", 2, 12, 1, 0, 0);
    startn = 1'b0;
    rst = 1'b1; #1;
    chk_out("rst.async", 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("rst.held_no_event", int'(state), 0);
    startn = 1'b1; cyc();
    press_start();
    chk_out("rst.repress", 2, 30, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
